// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one sum bit per clock
//
// Purpose:
//   Adds two WIDTH-bit operands LSB-first through a single 1-bit full-add
//   cell and a carry flop. Operands are captured on an accepted start,
//   WIDTH clocks of RUN produce the sum, then a one-cycle done strobe
//   presents the registered result.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      begin an addition (honoured in IDLE or DONE only)
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle strobe, sum/carry hold a new result
//   sum    out  WIDTH  registered (a+b) mod 2^WIDTH
//   carry  out  1      registered carry-out of the addition

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] psum_q,   psum_d;
   logic             c_q,      c_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             carry_q,  carry_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   // 1-bit full-add cell shared by every bit position
   logic             sum_bit;
   logic             c_next;
   logic [WIDTH-1:0] psum_shifted;

   always_comb begin
      sum_bit = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
      c_next  = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
      // New bit enters at the MSB; after WIDTH shifts bit 0 of the sum sits at
      // the LSB. Written as shift/or so WIDTH=1 needs no special case.
      psum_shifted = (psum_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      psum_d  = psum_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            // DONE honours start too, giving back-to-back operation
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               psum_d  = '0;
               c_d     = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            psum_d = psum_shifted;
            c_d    = c_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = psum_shifted;
               carry_d = c_next;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         psum_q  <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         psum_q  <= psum_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder

module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .carry (carry)
   );

   int               checks = 0;
   int               errors = 0;
   logic [WIDTH:0]   exp_q[$];      // {carry, sum}
   int               done_cyc[$];
   int               cyc = 0;
   int               busy_run = 0;
   logic [WIDTH-1:0] sum_hold = '0;
   logic             carry_hold = 1'b0;
   logic [WIDTH:0]   mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard on every done, checks busy length and that
   // the result outputs never move except on done or reset.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         busy_run   = 0;
         sum_hold   = '0;
         carry_hold = 1'b0;
      end else begin
         if (busy) busy_run++;
         if (done) begin
            done_cyc.push_back(cyc);
            chk("done_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               chk("sum", 32'(sum), 32'(mon_e[WIDTH-1:0]));
               chk("carry", 32'(carry), 32'(mon_e[WIDTH]));
            end
            chk("busy_cycles", 32'(busy_run), WIDTH);
            busy_run   = 0;
            sum_hold   = sum;
            carry_hold = carry;
         end else begin
            chk("result_held", 32'({carry, sum}), 32'({carry_hold, sum_hold}));
         end
      end
   end

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (n < 30) begin
         @(negedge clk);
         if (done) break;
         n++;
      end
      chk({name, "_done_seen"}, 32'(done), 1);
   endtask

   task automatic add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic [WIDTH:0] e, input string name);
      @(posedge clk); #1;
      a = x; b = y; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;

      // reset holds everything at zero even with start asserted
      repeat (2) begin
         @(negedge clk);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_sum", 32'(sum), 0);
         chk("rst_carry", 32'(carry), 0);
      end
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 0);

      add(8'h00, 8'h00, 9'h000, "zero");
      add(8'hFF, 8'h01, 9'h100, "ripple");
      add(8'hA5, 8'h5A, 9'h0FF, "alt");
      add(8'h80, 8'h80, 9'h100, "msb");

      // start and operand changes during RUN are ignored
      @(posedge clk); #1;
      a = 8'h12; b = 8'h34; start = 1'b1;
      exp_q.push_back(9'h046);
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) begin
         start = ~i[0];
         a     = i[0] ? 8'h5A : 8'hFF;
         b     = i[0] ? 8'hA5 : 8'hFF;
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_done("ignore");
      repeat (12) @(negedge clk);
      chk("ignore_no_second_op", 32'(busy), 0);

      // back-to-back: second operation accepted in the DONE cycle
      @(posedge clk); #1;
      a = 8'h0F; b = 8'h01; start = 1'b1;
      exp_q.push_back(9'h010);
      wait_done("b2b1");
      a = 8'hF0; b = 8'h20;
      exp_q.push_back(9'h110);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("b2b2");
      @(posedge clk); #1;
      chk("b2b_done_count", 32'(done_cyc.size() >= 2), 1);
      if (done_cyc.size() >= 2)
         chk("b2b_done_spacing", 32'(done_cyc[$] - done_cyc[$-1]), 9);

      // asynchronous reset mid-operation abandons it
      a = 8'hC3; b = 8'h3C; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      chk("async_rst_done", 32'(done), 0);
      chk("async_rst_sum", 32'(sum), 0);
      chk("async_rst_carry", 32'(carry), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abandoned_idle", 32'(busy), 0);
      add(8'hC3, 8'h3C, 9'h0FF, "after_rst");

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
